bnn_image_feeder: RTL and testbench
===================================

BNN_IMAGE_FEEDER -- requirements
Module: bnn_image_feeder

Interface
REQ-001 SHALL have parameter IMG_BYTES, default 784, meaning bytes per image frame (28x28, 8-bit pixels).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning buffer address width; IMG_BYTES <= 2^ADDR_W.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  in  1  buffer write strobe from the host side.
REQ-006 SHALL have port wr_addr  in  ADDR_W  buffer write address.
REQ-007 SHALL have port wr_data  in  8  pixel byte to write.
REQ-008 SHALL have port start  in  1  one-cycle request to transmit one frame.
REQ-009 SHALL have port start_cnn  out  1  one-cycle pulse telling the accelerator a frame begins.
REQ-010 SHALL have port image_tvalid  out  1  pixel valid toward the accelerator.
REQ-011 SHALL have port image_tdata  out  8  pixel byte.
REQ-012 SHALL have port image_tready  in  1  accelerator accepts pixel.
REQ-013 SHALL have port image_tlast  out  1  high with the final pixel of a frame.
REQ-014 SHALL have port busy  out  1  high from accepted start until done.
REQ-015 SHALL have port done  out  1  one-cycle pulse after the last pixel handshake.

Function
REQ-016 SHALL hold an IMG_BYTES x 8 buffer with one write port and one synchronous read port (1-cycle read latency).
REQ-017 SHALL write wr_data to wr_addr when wr_en=1 and busy=0; SHALL ignore writes while busy=1 and writes with wr_addr >= IMG_BYTES.
REQ-018 SHALL implement FSM states IDLE, PRIME, SEND, FIN.
REQ-019 IDLE: on start=1, SHALL load read address 0, assert start_cnn for that cycle's successor (one cycle), enter PRIME; start=1 in any other state SHALL be ignored.
REQ-020 PRIME: one cycle for buffer read latency; tvalid=0; SHALL enter SEND.
REQ-021 SEND: image_tvalid=1, image_tdata = buffer[idx], where idx is the current pixel index.
REQ-022 Handshake = image_tvalid & image_tready; on handshake with idx < IMG_BYTES-1 the read address SHALL advance to idx+1 so the next pixel is presented the following cycle (1 pixel/cycle with tready held high).
REQ-023 While image_tready=0, image_tdata, image_tlast and image_tvalid SHALL remain stable.
REQ-024 image_tlast SHALL be 1 exactly when in SEND and idx = IMG_BYTES-1.
REQ-025 On handshake at idx = IMG_BYTES-1, SHALL enter FIN; tvalid drops the next cycle.
REQ-026 FIN: done=1 for one cycle, busy=0 afterward, SHALL return to IDLE; a start in the FIN cycle SHALL be ignored.
REQ-027 busy SHALL be 1 in PRIME, SEND, FIN and in the cycle start_cnn is high; 0 in IDLE otherwise.
REQ-028 idx SHALL be ADDR_W bits, never exceed IMG_BYTES-1, and reset to 0 on every new frame (no wrap into a second frame).
REQ-029 Exactly IMG_BYTES handshakes SHALL occur per start; tvalid SHALL never be asserted outside SEND.
REQ-030 Buffer contents SHALL persist across frames; retransmitting without new writes SHALL repeat the identical byte sequence.

Reset
REQ-031 rst=1 at any clock edge SHALL force IDLE, idx=0, and start_cnn, image_tvalid, image_tlast, busy, done to 0 the next cycle, including mid-frame (partial frame abandoned, no done pulse).
REQ-032 Reset SHALL NOT clear buffer contents; image_tdata is don't-care while image_tvalid=0.
REQ-033 start asserted together with rst SHALL be ignored.

Verification
REQ-034 Load bytes 0..783 = addr mod 256, start, tready tied 1 -> start_cnn one pulse, first tvalid 2 cycles after start, 784 consecutive transfers 0x00,0x01,..,0x0F (addr 783), tlast only on last, done one cycle later.
REQ-035 Same frame, tready toggled 1,0,0,1 pattern -> every byte delivered once in order, tdata/tlast stable while stalled, exactly 784 handshakes.
REQ-036 Assert rst at pixel 300 -> tvalid, busy 0 next cycle, no done; new start resends from byte 0.
REQ-037 start pulsed during SEND and in FIN, wr_en to addr 5 with 0xAA while busy -> ignored; next frame byte 5 unchanged.
REQ-038 Two back-to-back starts after done, no writes between -> identical 784-byte sequences, two start_cnn and two done pulses.

Source files
------------

// File: rtl/bnn_image_feeder.sv
// rtl/bnn_image_feeder.sv - image frame buffer that streams one stored frame per start request
// Host writes pixels while idle; a start replays the whole buffer as a valid/ready stream.
module bnn_image_feeder #(
  parameter int IMG_BYTES = 784,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  output logic              start_cnn,
  output logic              image_tvalid,
  output logic [7:0]        image_tdata,
  input  logic              image_tready,
  output logic              image_tlast,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, PRIME, SEND, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_BYTES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] rd_addr;
  logic              start_cnn_q, start_cnn_d;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem [IMG_BYTES];
  logic              handshake;

  assign handshake = (state_q == SEND) && image_tready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    start_cnn_d = 1'b0;
    rd_addr     = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = PRIME;
          idx_d       = '0;
          start_cnn_d = 1'b1;
        end
      end
      PRIME: state_d = SEND;
      SEND: begin
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            // Fetch the next pixel now so it is on tdata right after the handshake.
            idx_d   = idx_q + 1'b1;
            rd_addr = idx_q + 1'b1;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      start_cnn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      start_cnn_q <= start_cnn_d;
    end
  end

  // Buffer is not reset so a frame survives reset and can be resent.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && (wr_addr <= LAST_IDX)) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign start_cnn    = start_cnn_q;
  assign image_tvalid = (state_q == SEND);
  assign image_tdata  = rd_data_q;
  assign image_tlast  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);

endmodule

// File: tb/tb_bnn_image_feeder.sv
// tb/tb_bnn_image_feeder.sv - scoreboard bench for bnn_image_feeder
module tb_bnn_image_feeder;

  localparam int N = 784;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       image_tready = 1'b0;
  logic       start_cnn, image_tvalid, image_tlast, busy, done;
  logic [7:0] image_tdata;

  bnn_image_feeder #(.IMG_BYTES(N), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_cnn(start_cnn), .image_tvalid(image_tvalid),
    .image_tdata(image_tdata), .image_tready(image_tready), .image_tlast(image_tlast),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [7:0] model [N];

  int cyc = 0, hs_cnt = 0, scnn_cnt = 0, done_cnt = 0;
  int stall_err = 0, valid_err = 0, first_hs = 0, last_hs = 0, done_cyc = 0;
  logic       prev_stall = 1'b0, prev_rst = 1'b1;
  logic [8:0] prev_beat = '0;

  // Monitor samples on the falling edge; rst seen here is what the next rising edge samples.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_stall && !prev_rst) begin
      if (!image_tvalid || ({image_tlast, image_tdata} !== prev_beat)) stall_err = stall_err + 1;
    end
    if (image_tvalid && !busy) valid_err = valid_err + 1;
    if (image_tvalid && image_tready && !rst) begin
      obs_q.push_back({image_tlast, image_tdata});
      if (hs_cnt == 0) first_hs = cyc;
      last_hs = cyc;
      hs_cnt = hs_cnt + 1;
    end
    if (start_cnn) scnn_cnt = scnn_cnt + 1;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    prev_stall = image_tvalid && !image_tready;
    prev_beat  = {image_tlast, image_tdata};
    prev_rst   = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    obs_q.delete();
    exp_q.delete();
    hs_cnt = 0; scnn_cnt = 0; done_cnt = 0; stall_err = 0; valid_err = 0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), model[i]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: tready held high; mode 1: repeating 1,0,0,1 pattern
  task automatic wait_done(input int mode, input int target);
    int k;
    k = 0;
    for (int i = 0; i < 6000 && done_cnt < target; i++) begin
      if (mode == 0) image_tready = 1'b1;
      else image_tready = ((k % 4) == 0) || ((k % 4) == 3);
      k++;
      tick();
    end
    image_tready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    vectors += 5;
    if (image_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got=%b exp=0", image_tvalid); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    if (start_cnn !== 1'b0) begin miscompares++; $display("FAIL reset_start_cnn got=%b exp=0", start_cnn); end
    if (image_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got=%b exp=0", image_tlast); end
    rst = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = 8'(i); model[i] = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [8:0] e, o;
    clear_mon();
    push_frame();
    image_tready = 1'b1;
    pulse_start();
    vectors += 3;
    if (start_cnn !== 1'b1) begin miscompares++; $display("FAIL stream_start_cnn got=%b exp=1", start_cnn); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL stream_busy_prime got=%b exp=1", busy); end
    if (image_tvalid !== 1'b0) begin miscompares++; $display("FAIL stream_prime_tvalid got=%b exp=0", image_tvalid); end
    tick();
    vectors += 2;
    if (image_tvalid !== 1'b1) begin miscompares++; $display("FAIL stream_first_tvalid got=%b exp=1", image_tvalid); end
    if (image_tdata !== model[0]) begin miscompares++; $display("FAIL stream_first_tdata got=%h exp=%h", image_tdata, model[0]); end
    wait_done(0, 1);
    vectors += 6;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL stream_done_cnt got=%0d exp=1", done_cnt); end
    if (scnn_cnt !== 1) begin miscompares++; $display("FAIL stream_start_cnn_cnt got=%0d exp=1", scnn_cnt); end
    if (hs_cnt !== N) begin miscompares++; $display("FAIL stream_hs_cnt got=%0d exp=%0d", hs_cnt, N); end
    if (last_hs - first_hs !== N - 1) begin miscompares++; $display("FAIL stream_consecutive got=%0d exp=%0d", last_hs - first_hs, N - 1); end
    if (done_cyc - last_hs !== 1) begin miscompares++; $display("FAIL stream_done_latency got=%0d exp=1", done_cyc - last_hs); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL stream_busy_end got=%b exp=0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL stream_missing got=none exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL stream_beat got=%h exp=%h", o, e); end
      end
    end
  endtask

  task automatic test_stall();
    logic [8:0] e, o;
    clear_mon();
    push_frame();
    pulse_start();
    wait_done(1, 1);
    vectors += 4;
    if (hs_cnt !== N) begin miscompares++; $display("FAIL stall_hs_cnt got=%0d exp=%0d", hs_cnt, N); end
    if (stall_err !== 0) begin miscompares++; $display("FAIL stall_stability got=%0d exp=0", stall_err); end
    if (done_cnt !== 1) begin miscompares++; $display("FAIL stall_done_cnt got=%0d exp=1", done_cnt); end
    if (valid_err !== 0) begin miscompares++; $display("FAIL stall_tvalid_outside got=%0d exp=0", valid_err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL stall_missing got=none exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL stall_beat got=%h exp=%h", o, e); end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [8:0] e, o;
    clear_mon();
    image_tready = 1'b1;
    pulse_start();
    for (int i = 0; i < 2000 && hs_cnt < 300; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors += 4;
    if (image_tvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_tvalid got=%b exp=0", image_tvalid); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (image_tlast !== 1'b0) begin miscompares++; $display("FAIL midrst_tlast got=%b exp=0", image_tlast); end
    if (hs_cnt !== 300) begin miscompares++; $display("FAIL midrst_partial got=%0d exp=300", hs_cnt); end
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (done_cnt !== 0) begin miscompares++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt); end
    clear_mon();
    push_frame();
    pulse_start();
    wait_done(0, 1);
    vectors++;
    if (hs_cnt !== N) begin miscompares++; $display("FAIL midrst_resend_cnt got=%0d exp=%0d", hs_cnt, N); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL midrst_missing got=none exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL midrst_beat got=%h exp=%h", o, e); end
      end
    end
  endtask

  task automatic test_ignore();
    logic [8:0] e, o;
    clear_mon();
    image_tready = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) tick();
    start = 1'b1; wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hAA;
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 2000 && done !== 1'b1; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_fin_busy got=%b exp=0", busy); end
    if (start_cnn !== 1'b0) begin miscompares++; $display("FAIL ignore_fin_start_cnn got=%b exp=0", start_cnn); end
    for (int i = 0; i < 5; i++) tick();
    vectors += 3;
    if (scnn_cnt !== 1) begin miscompares++; $display("FAIL ignore_start_cnn_cnt got=%0d exp=1", scnn_cnt); end
    if (hs_cnt !== N) begin miscompares++; $display("FAIL ignore_hs_cnt got=%0d exp=%0d", hs_cnt, N); end
    if (done_cnt !== 1) begin miscompares++; $display("FAIL ignore_done_cnt got=%0d exp=1", done_cnt); end
    clear_mon();
    push_frame();
    pulse_start();
    wait_done(0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL ignore_missing got=none exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL ignore_beat got=%h exp=%h", o, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e, o;
    clear_mon();
    push_frame();
    push_frame();
    pulse_start();
    wait_done(0, 1);
    pulse_start();
    wait_done(0, 2);
    vectors += 3;
    if (scnn_cnt !== 2) begin miscompares++; $display("FAIL b2b_start_cnn_cnt got=%0d exp=2", scnn_cnt); end
    if (done_cnt !== 2) begin miscompares++; $display("FAIL b2b_done_cnt got=%0d exp=2", done_cnt); end
    if (hs_cnt !== 2 * N) begin miscompares++; $display("FAIL b2b_hs_cnt got=%0d exp=%0d", hs_cnt, 2 * N); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL b2b_missing got=none exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL b2b_beat got=%h exp=%h", o, e); end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL b2b_extra got=%0d exp=0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_mid_reset();
    test_ignore();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
